// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default baud timing and data width.
// Used by the transmitter, the bit timer and the matching receiver.
// Build option: define UART_TX_PARITY_EN to add the PARITY state (8E1 frames).
package uart_pkg;

  // 50 MHz system clock at 110 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 454_545;
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned STATE_W              = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_START_BIT = 3'd1,
    ST_DATA_BITS = 3'd2,
    ST_STOP_BIT  = 3'd3,
`ifdef UART_TX_PARITY_EN
    ST_PARITY    = 3'd5,
`endif
    ST_CLEANUP   = 3'd4
  } uart_state_e;

`ifdef UART_TX_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction
`endif

endpackage : uart_pkg

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last count of each bit.
// Shared by the UART transmitter and receiver; the counter never exceeds CLKS_PER_BIT-1.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_last;

  assign w_last  = (r_count == CNT_LAST);
  assign bit_end = w_last;

  // Count within a bit; restart on clear or when the bit period completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear || w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule : uart_bit_timer

// File: rtl/uart_transmitter.sv
// UART transmitter: accepts one byte per valid/ready handshake and shifts it out
// LSB first as an 8N1 frame (start, 8 data, stop) at CLKS_PER_BIT clocks per bit.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
// Every output is registered from the next-state view, so the line falls in the
// cycle right after the handshake edge.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 uart_txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_e          r_state;
  uart_state_e          w_state_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [IDX_W-1:0]     w_bit_idx_next;
  logic                 r_tx_ready;
  logic                 r_uart_txd;
  logic                 r_tx_busy;
  logic                 r_tx_done;
  logic                 w_txd_next;
  logic                 w_ready_next;
  logic                 w_busy_next;
  logic                 w_done_next;
  logic                 w_timer_clear;
  logic                 w_bit_end;
  logic                 w_handshake;
  logic                 w_last_bit;

  assign w_handshake = tx_valid && r_tx_ready;
  assign w_last_bit  = (r_bit_idx == IDX_LAST);

  assign tx_ready = r_tx_ready;
  assign uart_txd = r_uart_txd;
  assign tx_busy  = r_tx_busy;
  assign tx_done  = r_tx_done;

  // Bit-period timing, held cleared outside the serialising states
  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_timer_clear),
    .bit_end (w_bit_end)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; unused encodings recover to IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_handshake) begin
          w_state_next = ST_START_BIT;
        end
      end
      ST_START_BIT: begin
        if (w_bit_end) begin
          w_state_next = ST_DATA_BITS;
        end
      end
      ST_DATA_BITS: begin
        if (w_bit_end && w_last_bit) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = ST_PARITY;
`else
          w_state_next = ST_STOP_BIT;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_next = ST_STOP_BIT;
        end
      end
`endif
      ST_STOP_BIT: begin
        if (w_bit_end) begin
          w_state_next = ST_CLEANUP;
        end
      end
      ST_CLEANUP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Output logic: values the output registers take on the coming edge
  always_comb begin
    w_timer_clear  = 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_txd_next     = 1'b1;
    w_ready_next   = (w_state_next == ST_IDLE);
    w_busy_next    = (w_state_next != ST_IDLE);
    w_done_next    = (r_state == ST_STOP_BIT) && w_bit_end;

    case (r_state)
      ST_START_BIT, ST_DATA_BITS, ST_STOP_BIT: w_timer_clear = 1'b0;
`ifdef UART_TX_PARITY_EN
      ST_PARITY:                               w_timer_clear = 1'b0;
`endif
      default:                                 w_timer_clear = 1'b1;
    endcase

    if (w_state_next != ST_DATA_BITS) begin
      w_bit_idx_next = '0;
    end else if ((r_state == ST_DATA_BITS) && w_bit_end) begin
      w_bit_idx_next = r_bit_idx + IDX_W'(1);
    end

    case (w_state_next)
      ST_START_BIT: w_txd_next = 1'b0;
      ST_DATA_BITS: w_txd_next = r_shift[w_bit_idx_next];
`ifdef UART_TX_PARITY_EN
      ST_PARITY:    w_txd_next = even_parity(r_shift);
`endif
      default:      w_txd_next = 1'b1;
    endcase
  end

  // Output, bit-index and shift registers; the byte is captured only on handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_uart_txd <= 1'b1;
      r_tx_ready <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      r_uart_txd <= w_txd_next;
      r_tx_ready <= w_ready_next;
      r_tx_busy  <= w_busy_next;
      r_tx_done  <= w_done_next;
      r_bit_idx  <= w_bit_idx_next;
      if (w_handshake) begin
        r_shift <= tx_data;
      end
    end
  end

endmodule : uart_transmitter
